// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder:
// default slice width and FSM state encodings.
package cla_pkg;

    localparam int DEFAULT_NBIT = 4;

    // 2'd3 is unused; the controller treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_slice.sv
// Purely combinational NBIT-bit carry-lookahead adder slice.
// Every carry is a flat OR of generate/propagate product terms.
module cla_slice #(
    parameter int NBIT = 4
) (
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            cin,
    output logic [NBIT-1:0] s,
    output logic            cout
);

    logic [NBIT-1:0] g;
    logic [NBIT-1:0] p;
    logic [NBIT:0]   c;
    logic            term;
    logic            acc;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = cin&p[i:0] | sum over j of g[j]&p[i:j+1], with no ripple through c.
    always_comb begin
        c    = '0;
        term = 1'b0;
        acc  = 1'b0;
        c[0] = cin;
        for (int i = 0; i < NBIT; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i+1] = acc;
        end
    end

    assign s    = p ^ c[NBIT-1:0];
    assign cout = c[NBIT];

endmodule

// File: rtl/cla_seq_ctrl.sv
// Multi-precision add sequencer: one shared CLA slice adds a W-bit pair
// chunk by chunk, LSB chunk first, with the inter-chunk carry registered.
module cla_seq_ctrl
    import cla_pkg::*;
#(
    parameter int NBIT   = DEFAULT_NBIT,
    parameter int NCHUNK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBIT*NCHUNK-1:0] a,
    input  logic [NBIT*NCHUNK-1:0] b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBIT*NCHUNK-1:0] sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int W  = NBIT * NCHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            cout_reg;
    logic [NBIT-1:0] slice_a;
    logic [NBIT-1:0] slice_b;
    logic [NBIT-1:0] slice_s;
    logic            slice_cout;
    logic            last_chunk;
    logic            accept;

    assign last_chunk = (idx == IW'(NCHUNK - 1));
    assign accept     = (state == IDLE) && in_valid;
    assign slice_a    = a_reg[int'(idx) * NBIT +: NBIT];
    assign slice_b    = b_reg[int'(idx) * NBIT +: NBIT];

    cla_slice #(
        .NBIT (NBIT)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = in_valid ? RUN : IDLE;
            RUN:     next_state = last_chunk ? DONE : RUN;
            DONE:    next_state = out_ready ? IDLE : DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            RUN:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Operands are captured only at accept, so input changes while busy are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            carry   <= cin;
            idx     <= '0;
            sum_reg <= '0;
        end else if (state == RUN) begin
            sum_reg[int'(idx) * NBIT +: NBIT] <= slice_s;
            carry <= slice_cout;
            idx   <= last_chunk ? '0 : idx + IW'(1);
            if (last_chunk) begin
                cout_reg <= slice_cout;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: doc/cla_seq_ctrl.md
Name: cla_seq_ctrl

Overview:
- Multi-precision add sequencer: adds two W-bit operands, W = NBIT*NCHUNK, over NCHUNK clock cycles.
- Time-multiplexes a single NBIT-wide carry-lookahead slice, one chunk per cycle, LSB chunk first.
- Inter-chunk carry is registered between cycles.
- Sits between a valid/ready producer and consumer; used wherever a wide add is needed without paying for a W-bit CLA tree.

Parameters:
- NBIT, 4, width of one CLA slice (bits added per cycle).
- NCHUNK, 4, number of chunks; total operand width W = NBIT*NCHUNK; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept an operation.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  (a + b + cin) mod 2^W.
- cout  output  1  carry out of bit W-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry=0, operand regs=0, sum=0, cout=0, out_valid=0, busy=0. in_ready=1 once rst_n is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: latch a and b into operand regs, carry<=cin, idx<=0, sum<=0, go to RUN.
  - No accept: stay in IDLE.
- RUN:
  - in_ready=0.
  - Slice inputs: a_reg[idx*NBIT +: NBIT], b_reg[idx*NBIT +: NBIT], carry.
  - Each edge: sum[idx*NBIT +: NBIT]<=slice sum, carry<=slice cout, idx<=idx+1.
  - On the edge where idx==NCHUNK-1: cout<=slice cout, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid drops on the next cycle.
- Latency: accept edge at cycle 0; out_valid high from cycle NCHUNK, after NCHUNK RUN edges.
- Minimum issue interval: NCHUNK+2 cycles, with out_ready held high.
- No same-cycle result drain plus new accept: in_ready is 0 in DONE by definition.
- Operand isolation: a and b are sampled only at the accept edge. Input changes during RUN/DONE have no effect.
- Overflow: sum wraps modulo 2^W; the carry beyond bit W-1 appears only on cout.
- NCHUNK=1: one RUN cycle, then DONE.
- idx width: max(1, clog2(NCHUNK)).
- Reset mid-operation (RUN or DONE): the operation is discarded, no out_valid is produced, and all outputs return to reset values immediately.
- in_valid while busy: ignored, not queued. The producer must hold it until in_ready.
- Outputs are registered. in_ready is decoded from state only, with no combinational path from in_valid or out_ready.

Decomposition:
- Shared package/header cla_pkg:
  - default NBIT;
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
- One natural sub-module, cla_slice:
  - purely combinational NBIT-bit carry-lookahead adder (a, b, cin -> s, cout);
  - g=a&b, p=a^b; c[0]=cin; c[i+1]=g[i] | (p[i]&c[i]), expanded to lookahead form;
  - cout=c[NBIT], s=p^c[NBIT-1:0].
- Instantiated once; cla_seq_ctrl holds the FSM, idx counter, carry, operand and result registers.

Test Plan:
All scenarios use NBIT=4, NCHUNK=4 (W=16).
- Basic: a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0; out_valid rises exactly 4 cycles after the accept edge.
- Full ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; also a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum/cout stable, in_ready=0; an in_valid pulse with a=16'h0001 during this is ignored. Raise out_ready -> one handshake, then IDLE with in_ready=1.
- Operand isolation: accept a=16'h00F0, b=16'h0010, then drive a=b=16'hFFFF during RUN -> sum=16'h0100, cout=0.
- Reset mid-op: assert rst_n low after 2 RUN cycles -> sum=0, cout=0, out_valid=0, busy=0 asynchronously. After release, a=16'h00FF, b=16'h0001, cin=0 -> sum=16'h0100, cout=0.
- Random: 1000 ops with random a, b, cin, random in_valid/out_ready stalls -> every result equals {cout,sum} = a+b+cin; no lost or duplicated results; also repeat with NCHUNK=1.
